// File: rtl/serial_bit_tx.sv
// Purpose: serialises one DATA_W-bit word per frame (start, LSB-first data, optional even parity, stop).
// Latency: sdo changes on the 3rd clk edge after a scaled_clk rise (2-flop sync + edge detect + output flop).
// Backpressure: tx_ready is high only in IDLE; tx_valid and tx_data are ignored while a frame is armed or in flight.
module serial_bit_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              scaled_clk,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              sdo,
  output logic              frame_done
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int STOP_W = $clog2(STOP_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, hist_q;
  logic                bit_tick;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STOP_W-1:0]   stop_q, stop_d;
  logic                sdo_q, sdo_d;
  logic                frame_done_c;

  // scaled_clk is only data here: synchronise it, keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= scaled_clk;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // one-cycle pulse per rising edge of the synchronised bit-rate clock
  assign bit_tick = sync2_q & ~hist_q;

  // frame state and datapath registers; reset forces the line high at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      stop_q   <= '0;
      sdo_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      sdo_q    <= sdo_d;
    end
  end

  // next-state and line value; every move except the accept waits for a bit_tick
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    cnt_d        = cnt_q;
    stop_d       = stop_q;
    sdo_d        = sdo_q;
    frame_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        // an accept wins over a coincident tick, so START waits for the following tick
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = ^tx_data;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (bit_tick) begin
          state_d = START;
          sdo_d   = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          sdo_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
      end
      DATA: begin
        // cnt_q is the index of the bit currently on the line
        if (bit_tick) begin
          if (cnt_q == LAST_BIT) begin
            if (PARITY_EN == 1) begin
              state_d = PARITY;
              sdo_d   = parity_q;
            end else begin
              state_d = STOP;
              sdo_d   = 1'b1;
              stop_d  = '0;
            end
          end else begin
            sdo_d   = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          sdo_d   = 1'b1;
          stop_d  = '0;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_q == LAST_STOP) begin
            state_d      = IDLE;
            frame_done_c = 1'b1;
          end else begin
            stop_d = stop_q + STOP_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        sdo_d   = 1'b1;
      end
    endcase
  end

  assign tx_ready   = (state_q == IDLE);
  assign tx_busy    = (state_q != IDLE);
  assign sdo        = sdo_q;
  assign frame_done = frame_done_c;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: two instances (parity/1 stop and no parity/2 stop).
// scaled_clk is driven as 4 clk high / 4 clk low; sdo is sampled late in each high phase.
// All inputs change on the falling clk edge.
module tb_serial_bit_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sc_a, tv_a, rdy_a, busy_a, sdo_a, fd_a;
  logic       sc_b, tv_b, rdy_b, busy_b, sdo_b, fd_b;
  logic [7:0] td_a, td_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt_a = 0;
  int fd_cnt_b = 0;
  int fd_cyc = -1;
  int acc_cyc = -1;

  // frames listed bit-period by bit-period, index 0 = start bit
  localparam logic [10:0] EXP_A5 = 11'b10101001010;
  localparam logic [10:0] EXP_07 = 11'b11000001110;
  localparam logic [10:0] EXP_01 = 11'b11000000010;
  localparam logic [10:0] EXP_80 = 11'b11100000000;
  localparam logic [10:0] EXP_3C = 11'b10001111000;
  localparam logic [10:0] EXP_5A = 11'b11010110100;

  always #5 clk = ~clk;

  serial_bit_tx #(.DATA_W(8), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rstn(rstn), .scaled_clk(sc_a), .tx_data(td_a), .tx_valid(tv_a),
    .tx_ready(rdy_a), .tx_busy(busy_a), .sdo(sdo_a), .frame_done(fd_a)
  );

  serial_bit_tx #(.DATA_W(8), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rstn(rstn), .scaled_clk(sc_b), .tx_data(td_b), .tx_valid(tv_b),
    .tx_ready(rdy_b), .tx_busy(busy_b), .sdo(sdo_b), .frame_done(fd_b)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fd_a === 1'b1) begin
      fd_cnt_a = fd_cnt_a + 1;
      fd_cyc = cyc;
    end
    if (fd_b === 1'b1) fd_cnt_b = fd_cnt_b + 1;
    if (tv_a === 1'b1 && rdy_a === 1'b1) acc_cyc = cyc;
  end

  task automatic sc_period(input bit b, output logic s, output int rdy_hi);
    rdy_hi = 0;
    if (b) sc_b = 1'b1; else sc_a = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if ((b ? rdy_b : rdy_a) === 1'b1) rdy_hi++;
    end
    s = b ? sdo_b : sdo_a;
    if (b) sc_b = 1'b0; else sc_a = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if ((b ? rdy_b : rdy_a) === 1'b1) rdy_hi++;
    end
  endtask

  task automatic accept(input bit b, input logic [7:0] d, input string name);
    if (b) begin tv_b = 1'b1; td_b = d; end
    else   begin tv_a = 1'b1; td_a = d; end
    @(negedge clk);
    if (b) tv_b = 1'b0; else tv_a = 1'b0;
    checks++;
    if ((b ? busy_b : busy_a) !== 1'b1 || (b ? rdy_b : rdy_a) !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b ready=%b, expected busy=1 ready=0", name,
               b ? busy_b : busy_a, b ? rdy_b : rdy_a);
    end
  endtask

  task automatic run_bits(input bit b, input logic [10:0] exp, input int lo, input int hi,
                          input string name);
    logic s;
    int   r;
    int   f0;
    f0 = b ? fd_cnt_b : fd_cnt_a;
    for (int i = lo; i <= hi; i++) begin
      sc_period(b, s, r);
      checks++;
      if (s !== exp[i]) begin
        errors++;
        $display("FAIL %s bit period %0d: sdo=%b expected %b", name, i, s, exp[i]);
      end
      checks++;
      if (r != 0) begin
        errors++;
        $display("FAIL %s ready in period %0d: high for %0d cycles, expected 0", name, i, r);
      end
    end
    checks++;
    if ((b ? fd_cnt_b : fd_cnt_a) != f0) begin
      errors++;
      $display("FAIL %s early frame_done: %0d pulses, expected 0", name,
               (b ? fd_cnt_b : fd_cnt_a) - f0);
    end
  endtask

  task automatic finish_frame(input bit b, input bit expect_idle, input string name);
    logic s;
    int   r;
    int   f0;
    f0 = b ? fd_cnt_b : fd_cnt_a;
    sc_period(b, s, r);
    checks++;
    if ((b ? fd_cnt_b : fd_cnt_a) - f0 != 1) begin
      errors++;
      $display("FAIL %s frame_done: %0d pulses, expected 1", name, (b ? fd_cnt_b : fd_cnt_a) - f0);
    end
    checks++;
    if (s !== 1'b1) begin
      errors++;
      $display("FAIL %s line after frame: sdo=%b expected 1", name, s);
    end
    checks++;
    if ((b ? busy_b : busy_a) !== !expect_idle) begin
      errors++;
      $display("FAIL %s busy after frame: %b expected %b", name, b ? busy_b : busy_a, !expect_idle);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    sc_a = 1'b1; sc_b = 1'b0;
    tv_a = 1'b0; tv_b = 1'b0;
    td_a = 8'h00; td_b = 8'h00;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sdo_a !== 1'b1 || sdo_b !== 1'b1) begin
      errors++;
      $display("FAIL reset sdo: a=%b b=%b expected 1", sdo_a, sdo_b);
    end
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: a=%b b=%b expected 0", busy_a, busy_b);
    end
    checks++;
    if (fd_a !== 1'b0 || fd_b !== 1'b0) begin
      errors++;
      $display("FAIL reset frame_done: a=%b b=%b expected 0", fd_a, fd_b);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      errors++;
      $display("FAIL release ready: a=%b b=%b expected 1", rdy_a, rdy_b);
    end
    checks++;
    if (dut_a.bit_tick !== 1'b0) begin
      errors++;
      $display("FAIL release tick: bit_tick=%b expected 0", dut_a.bit_tick);
    end
    sc_a = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || sdo_a !== 1'b1) begin
      errors++;
      $display("FAIL idle after release: busy=%b sdo=%b expected 0/1", busy_a, sdo_a);
    end
  endtask

  task automatic test_basic_frame();
    accept(1'b0, 8'hA5, "basic");
    run_bits(1'b0, EXP_A5, 0, 10, "basic");
    finish_frame(1'b0, 1'b1, "basic");
  endtask

  task automatic test_parity_ignore_valid();
    accept(1'b0, 8'h07, "parity");
    // offering another word mid-frame must not disturb it
    tv_a = 1'b1; td_a = 8'hFF;
    run_bits(1'b0, EXP_07, 0, 10, "parity");
    tv_a = 1'b0;
    finish_frame(1'b0, 1'b1, "parity");
  endtask

  task automatic test_back_to_back();
    acc_cyc = -1;
    tv_a = 1'b1; td_a = 8'h01;
    @(negedge clk);
    td_a = 8'h80;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b first accept: busy=%b expected 1", busy_a);
    end
    run_bits(1'b0, EXP_01, 0, 10, "b2b_first");
    finish_frame(1'b0, 1'b0, "b2b_first");
    tv_a = 1'b0;
    checks++;
    if (acc_cyc != fd_cyc + 1) begin
      errors++;
      $display("FAIL b2b accept timing: accept cycle %0d, expected %0d", acc_cyc, fd_cyc + 1);
    end
    run_bits(1'b0, EXP_80, 0, 10, "b2b_second");
    finish_frame(1'b0, 1'b1, "b2b_second");
  endtask

  task automatic test_accept_on_tick();
    sc_a = 1'b1;
    repeat (2) @(negedge clk);
    tv_a = 1'b1; td_a = 8'h3C;
    checks++;
    if (dut_a.bit_tick !== 1'b1) begin
      errors++;
      $display("FAIL tick alignment: bit_tick=%b expected 1", dut_a.bit_tick);
    end
    @(negedge clk);
    tv_a = 1'b0;
    repeat (2) @(negedge clk);
    sc_a = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || sdo_a !== 1'b1) begin
      errors++;
      $display("FAIL accept on tick: busy=%b sdo=%b expected 1/1", busy_a, sdo_a);
    end
    run_bits(1'b0, EXP_3C, 0, 10, "tick_accept");
    finish_frame(1'b0, 1'b1, "tick_accept");
  endtask

  task automatic test_midframe_reset();
    logic s;
    int   r;
    int   f0;
    accept(1'b0, 8'hA5, "midrst");
    run_bits(1'b0, EXP_A5, 0, 4, "midrst");
    f0 = fd_cnt_a;
    rstn = 1'b0;
    #1;
    checks++;
    if (sdo_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst async: sdo=%b busy=%b expected 1/0", sdo_a, busy_a);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst ready: %b expected 1", rdy_a);
    end
    for (int i = 0; i < 3; i++) begin
      sc_period(1'b0, s, r);
      checks++;
      if (s !== 1'b1 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL midrst resumed period %0d: sdo=%b busy=%b expected 1/0", i, s, busy_a);
      end
    end
    checks++;
    if (fd_cnt_a != f0) begin
      errors++;
      $display("FAIL midrst frame_done: %0d pulses, expected 0", fd_cnt_a - f0);
    end
  endtask

  task automatic test_stalled_divider();
    logic s0;
    int   dev;
    accept(1'b1, 8'h5A, "stall");
    run_bits(1'b1, EXP_5A, 0, 3, "stall");
    s0 = sdo_b;
    dev = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sdo_b !== s0 || busy_b !== 1'b1 || rdy_b !== 1'b0 || fd_b !== 1'b0) dev++;
    end
    checks++;
    if (dev != 0) begin
      errors++;
      $display("FAIL stall hold: %0d cycles changed, expected 0", dev);
    end
    checks++;
    if (dut_b.cnt_q !== 4'd2) begin
      errors++;
      $display("FAIL stall bit counter: %0d expected 2", dut_b.cnt_q);
    end
    run_bits(1'b1, EXP_5A, 4, 10, "stall");
    finish_frame(1'b1, 1'b1, "stall");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_ignore_valid();
    test_back_to_back();
    test_accept_on_tick();
    test_midframe_reset();
    test_stalled_divider();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
